fetch_unit: RTL

Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter, drives the word address into the combinational instruction memory, and captures the returned word with its PC into a small buffer. The buffer feeds the decode stage over a valid/ready handshake. Taken branches and jumps redirect the PC and flush any instructions already fetched.

---
 rtl/core_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 42 ++++
 rtl/fetch_unit_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 66 ++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage and its buffer.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Signals between the fetch stage, the instruction memory and decode/execute.
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    import core_pkg::*;

    logic              redirect_i;
    logic [XLEN-1:0]   redirect_pc_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [XLEN-1:0]   imem_data_i;
    logic [XLEN-1:0]   instr_o;
    logic [XLEN-1:0]   pc_o;
    logic              valid_o;
    logic              ready_i;
    logic              misalign_o;

    // The fetch stage owns the outputs; the surrounding pipeline owns the rest.
    modport master (
        input  redirect_i,
        input  redirect_pc_i,
        input  imem_data_i,
        input  ready_i,
        output imem_addr_o,
        output instr_o,
        output pc_o,
        output valid_o,
        output misalign_o
    );

    modport slave (
        output redirect_i,
        output redirect_pc_i,
        output imem_data_i,
        output ready_i,
        input  imem_addr_o,
        input  instr_o,
        input  pc_o,
        input  valid_o,
        input  misalign_o
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry fetch buffer holding {pc, instr} pairs; flush empties it in one edge.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o,
    output logic         full_o
);

    fetch_entry_t r_mem [DEPTH];
    logic         r_rdPtr;
    logic         r_wrPtr;
    logic [1:0]   r_count;

    // Pointers are one bit wide, so they wrap naturally over the two slots.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (push_i) begin
                r_mem[r_wrPtr] <= entry_i;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (pop_i) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign count_o = r_count;
    assign head_o  = r_mem[r_rdPtr];
    assign full_o  = (r_count == 2'd2);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses the instruction memory and buffers
// fetched words for decode behind a valid/ready handshake.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 2
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    fetch_unit_if.master  bus
);

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;

    logic            w_valid;
    logic            w_pop;
    logic            w_full;
    logic            w_fetchEn;
    logic [1:0]      w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_newEntry;

    assign w_valid    = (w_count != 2'd0);
    assign w_pop      = w_valid & bus.ready_i;
    assign w_fetchEn  = !bus.redirect_i & (!w_full | w_pop);
    assign w_newEntry = '{pc: r_pc, instr: bus.imem_data_i};

    // A redirect outranks everything; otherwise the PC only advances on a real fetch.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= bus.redirect_i & (|bus.redirect_pc_i[1:0]);
            if (bus.redirect_i) begin
                r_pc <= wordAlign(bus.redirect_pc_i);
            end else if (w_fetchEn) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_fetchEn),
        .entry_i (w_newEntry),
        .pop_i   (w_pop & !bus.redirect_i),
        .flush_i (bus.redirect_i),
        .count_o (w_count),
        .head_o  (w_head),
        .full_o  (w_full)
    );

    assign bus.imem_addr_o = r_pc[ADDR_W+1:2];
    assign bus.valid_o     = w_valid;
    assign bus.instr_o     = w_valid ? w_head.instr : NOP_INSTR;
    assign bus.pc_o        = w_valid ? w_head.pc : '0;
    assign bus.misalign_o  = r_misalign;

endmodule
